// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM states
// and the circular pointer advance used when an owner releases.
package arb_pkg;

   localparam int NREQ  = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE,
      GRANT
   } state_e;

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
      return IDX_W'((int'(idx) + 1) % NREQ);
   endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// Combinational 8-to-3 encoder; assumes a zero or one-hot input and
// yields 0 for an all-zero vector.
module onehot_to_idx
   import arb_pkg::*;
(
   input  logic [NREQ-1:0]  onehot_i,
   output logic [IDX_W-1:0] idx_o
);

   always_comb begin
      idx_o = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (onehot_i[i]) begin
            idx_o = idx_o | IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a per-owner hold limit.
// Grant, index and preempt are registered; priority rotates past each released owner.
module rr_arbiter_8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             preempt
);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              preempt_q, preempt_d;
   logic              ownerReq, holdDone;
   logic [NREQ-1:0]   gatedReq;

   // Walk from the far end back toward base so the request nearest base wins.
   function automatic logic [NREQ-1:0] rrPick(input logic [NREQ-1:0]  r,
                                              input logic [IDX_W-1:0] base);
      logic [NREQ-1:0]  pick;
      logic [IDX_W-1:0] pos;
      pick = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         pos = base + IDX_W'(i);
         if (r[pos]) begin
            pick      = '0;
            pick[pos] = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      grant_d   = grant_q;
      preempt_d = 1'b0;
      gatedReq  = req & {NREQ{en}};
      ownerReq  = |(req & grant_q);
      holdDone  = (hold_q == HOLD_W'(MAX_HOLD - 1));
      case (state_q)
         IDLE: begin
            grant_d = rrPick(gatedReq, ptr_q);
            state_d = (|grant_d) ? GRANT : IDLE;
         end
         GRANT: begin
            // On release the next winner is chosen from the advanced pointer in the same cycle.
            if (!ownerReq || holdDone) begin
               ptr_d     = next_ptr(idx_q);
               hold_d    = '0;
               preempt_d = ownerReq;
               grant_d   = rrPick(gatedReq, ptr_d);
               state_d   = (|grant_d) ? GRANT : IDLE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   onehot_to_idx u_enc (
      .onehot_i (grant_d),
      .idx_o    (idx_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         hold_q    <= '0;
         grant_q   <= '0;
         idx_q     <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         grant_q   <= grant_d;
         idx_q     <= idx_d;
         preempt_q <= preempt_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = idx_q;
   assign grant_valid = |grant_q;
   assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 (hold limit 4): directed scenarios plus
// randomized traffic, all compared against an owner/pointer reference model.
module tb_rr_arbiter_8;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] req = 8'h00;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   rr_arbiter_8 #(.MAX_HOLD(MAXH), .HOLD_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .preempt     (preempt)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the resource, where the scan starts, how long it has been held.
   int mOwner = -1;
   int mPtr = 0;
   int mHold = 0;
   bit mPreempt = 1'b0;
   int mBase;
   bit mPick;

   always @(posedge clk) begin
      if (!rst_n) begin
         mOwner = -1; mPtr = 0; mHold = 0; mPreempt = 1'b0;
      end else begin
         mPreempt = 1'b0;
         mPick = 1'b0;
         mBase = mPtr;
         if (mOwner < 0) begin
            mPick = 1'b1;
         end else if (req[mOwner] == 1'b0 || mHold == MAXH - 1) begin
            mPreempt = req[mOwner];
            mPtr = (mOwner + 1) % 8;
            mBase = mPtr;
            mHold = 0;
            mOwner = -1;
            mPick = 1'b1;
         end else begin
            mHold = mHold + 1;
         end
         if (mPick && en) begin
            for (int j = 0; j < 8; j++) begin
               if (mOwner < 0 && req[(mBase + j) % 8]) mOwner = (mBase + j) % 8;
            end
         end
      end
   end

   function automatic logic [12:0] expVec();
      logic [7:0] g;
      logic [2:0] ix;
      g  = (mOwner < 0) ? 8'h00 : 8'(1 << mOwner);
      ix = (mOwner < 0) ? 3'd0 : 3'(mOwner);
      return {g, ix, (mOwner >= 0), mPreempt};
   endfunction

   task automatic applyStimulus(input logic r, input logic e, input logic [7:0] q);
      @(negedge clk);
      rst_n = r; en = e; req = q;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 5; c++) begin
         if (c < 2) applyStimulus(1'b0, 1'b1, 8'hFF);
         else applyStimulus(1'b1, 1'b0, 8'hFF);
         checks++;
         if ({grant, grant_idx, grant_valid, preempt} !== 13'h0) begin
            errors++;
            $display("[TB] FAIL reset_idle cycle %0d got %h want 0000", c, {grant, grant_idx, grant_valid, preempt});
         end
      end
   endtask

   task automatic test_single();
      applyStimulus(1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, 1'b1, 8'b0000_0100);
         checks++;
         if (grant !== 8'h04 || grant_idx !== 3'd2 || grant_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_grant cycle %0d got %h/%0d want 04/2", c, grant, grant_idx);
         end
         checks++;
         if ({grant, grant_idx, grant_valid, preempt} !== expVec()) begin
            errors++;
            $display("[TB] FAIL single_model got %h want %h", {grant, grant_idx, grant_valid, preempt}, expVec());
         end
      end
      applyStimulus(1'b1, 1'b1, 8'h00);
      checks++;
      if (grant !== 8'h00 || grant_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_drop got %h want 00", grant);
      end
      // Pointer should now sit at 3, so 3 beats 0.
      applyStimulus(1'b1, 1'b1, 8'b0000_1001);
      checks++;
      if (grant_idx !== 3'd3) begin
         errors++;
         $display("[TB] FAIL single_ptr got %0d want 3", grant_idx);
      end
   endtask

   task automatic test_rotation();
      int order[$];
      int held;
      logic [7:0] q;
      int want[4] = '{0, 1, 7, 0};
      applyStimulus(1'b0, 1'b0, 8'h00);
      held = 0;
      q = 8'h83;
      for (int c = 0; c < 7; c++) begin
         applyStimulus(1'b1, 1'b1, q);
         checks++;
         if (grant_valid !== 1'b1 || {grant, grant_idx, grant_valid, preempt} !== expVec()) begin
            errors++;
            $display("[TB] FAIL rotation_cycle %0d got %h want %h", c, {grant, grant_idx, grant_valid, preempt}, expVec());
         end
         if (order.size() == 0 || order[$] != int'(grant_idx) || held == 2) begin
            order.push_back(int'(grant_idx));
            held = 1;
         end else begin
            held++;
         end
         q = (held == 2) ? (8'h83 & ~grant) : 8'h83;
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (k >= order.size() || order[k] != want[k]) begin
            errors++;
            $display("[TB] FAIL rotation_order pos %0d got %0d want %0d", k, (k < order.size()) ? order[k] : -1, want[k]);
         end
      end
   endtask

   task automatic test_hold_limit();
      int wantIdx[9] = '{0, 0, 0, 0, 5, 5, 5, 5, 0};
      bit wantPre[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
      applyStimulus(1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 9; c++) begin
         applyStimulus(1'b1, 1'b1, 8'b0010_0001);
         checks++;
         if (grant_idx !== 3'(wantIdx[c]) || preempt !== wantPre[c] || grant_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_limit cycle %0d got idx %0d pre %b want idx %0d pre %b", c, grant_idx, preempt, wantIdx[c], wantPre[c]);
         end
      end
   endtask

   task automatic test_wrap();
      applyStimulus(1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b1, 8'h80);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, 1'b1, 8'b1000_0010);
         checks++;
         if ({grant, grant_idx, grant_valid, preempt} !== expVec()) begin
            errors++;
            $display("[TB] FAIL wrap_model cycle %0d got %h want %h", c, {grant, grant_idx, grant_valid, preempt}, expVec());
         end
         if (c >= 3) begin
            checks++;
            if (grant_idx !== 3'd1 || grant !== 8'h02) begin
               errors++;
               $display("[TB] FAIL wrap_next cycle %0d got %0d want 1", c, grant_idx);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      applyStimulus(1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b1, 8'h08);
      checks++;
      if (grant_idx !== 3'd3 || grant !== 8'h08) begin
         errors++;
         $display("[TB] FAIL midrst_owner got %0d want 3", grant_idx);
      end
      applyStimulus(1'b0, 1'b1, 8'h08);
      checks++;
      if ({grant, grant_idx, grant_valid, preempt} !== 13'h0) begin
         errors++;
         $display("[TB] FAIL midrst_clear got %h want 0000", {grant, grant_idx, grant_valid, preempt});
      end
      applyStimulus(1'b1, 1'b1, 8'b0000_1001);
      checks++;
      if (grant_idx !== 3'd0 || grant !== 8'h01) begin
         errors++;
         $display("[TB] FAIL midrst_ptr got %0d want 0", grant_idx);
      end
   endtask

   task automatic test_random();
      logic [7:0] q;
      logic e, r;
      applyStimulus(1'b0, 1'b0, 8'h00);
      q = 8'($urandom);
      for (int c = 0; c < 600; c++) begin
         q = q ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         e = ($urandom_range(0, 7) != 0);
         r = ($urandom_range(0, 99) != 0);
         applyStimulus(r, e, q);
         checks++;
         if ({grant, grant_idx, grant_valid, preempt} !== expVec()) begin
            errors++;
            $display("[TB] FAIL random_model cycle %0d req %h got %h want %h", c, q, {grant, grant_idx, grant_valid, preempt}, expVec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_hold_limit();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
Round-robin arbiter that shares one downstream resource between 8 requesters. Each cycle it picks at most one winner and drives both a one-hot grant and the 3-bit encoded index of that grant. A grant is held until the owner drops its request or a hold limit expires, which gives fair rotation and bounded latency. It sits in front of any shared datapath that the team feeds through an 8-to-3 index.

Parameters:
NREQ, 8, number of requesters (design and verification target 8 only)
IDX_W, 3, width of the encoded grant index, equal to log2(NREQ)
MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant (legal range 1..2^HOLD_W)
HOLD_W, 4, width of the hold counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
en  input  1  arbitration enable; while low, no new grant is issued
req  input  NREQ  request vector, bit i high = requester i wants the resource
grant  output  NREQ  one-hot grant, registered
grant_idx  output  IDX_W  encoded index of the granted requester, registered
grant_valid  output  1  high when grant is non-zero
preempt  output  1  one-cycle pulse: the current grant was released by the hold limit

Behaviour:
- Reset (rst_n low at a clk edge): grant=0, grant_idx=0, grant_valid=0, preempt=0, priority pointer ptr=0, hold_cnt=0, state=IDLE. Reset wins over all other inputs. Reset while a grant is held drops it on the next edge.
- Selection function: the winner is the first set bit of req scanning circularly from ptr upward (ptr, ptr+1, ..., 7, 0, ..., ptr-1). If req=0 there is no winner.
- State IDLE: if en=1 and req is non-zero, the winner is registered and the state moves to GRANT. grant, grant_idx and grant_valid appear exactly 1 cycle after req is sampled. Otherwise the block stays in IDLE with outputs 0.
- State GRANT, owner k:
  - hold_cnt counts from 0, incrementing each cycle the grant is held.
  - Release condition: req[k]=0, or hold_cnt==MAX_HOLD-1.
  - No release: grant stays at k and hold_cnt increments.
  - On release:
    - ptr becomes (k+1) mod 8, wrapping 7 to 0.
    - hold_cnt becomes 0.
    - preempt=1 for the next cycle only if the release came from the hold limit while req[k] was still 1.
  - Back-to-back: in the release cycle, a new winner is selected using the updated ptr, over the current req and gated by en. If a winner exists, grant moves to it on the next edge with no idle cycle. Otherwise the state goes to IDLE and grant becomes 0.
  - A preempted owner that is still requesting is therefore lowest priority. It regains the grant immediately only if it is the sole requester.
- en low during GRANT does not revoke the current owner. At release the block goes to IDLE.
- grant is always zero or one-hot. grant_idx always equals the encoding of grant (0 when grant=0). grant_valid = |grant.
- Changes to req bits other than the owner's never affect the current grant.
- MAX_HOLD=1 forces a rotation every cycle under continuous requests.

Decomposition:
- Shared package arb_pkg holds: NREQ and IDX_W constants, the state enum {IDLE, GRANT}, and the function next_ptr(idx) = (idx+1) mod NREQ.
- Natural sub-module: onehot_to_idx, a combinational 8-to-3 one-hot encoder producing grant_idx from the next-grant vector. It is instantiated once, and its output is registered in rr_arbiter_8.
- The circular priority select stays in the top module.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with req=8'hFF, then rst_n=1, en=0 for 3 cycles -> grant=0, grant_idx=0, grant_valid=0 throughout.
- Single requester: en=1, req=8'b0000_0100 held 5 cycles then dropped -> grant=8'b0000_0100 and grant_idx=2 from cycle 1; grant=0 one cycle after the drop; ptr becomes 3.
- Rotation fairness: ptr=0, req=8'b1000_0011, each owner drops req after 2 cycles then reasserts -> grant order idx 0, 1, 7, 0 with no idle gap between grants.
- Hold limit: MAX_HOLD=4, req=8'b0010_0001 held constantly -> idx 0 for 4 cycles, preempt pulse, idx 5 for 4 cycles, preempt pulse, idx 0 again.
- Wrap-around: owner idx 7 releases while req=8'b1000_0010 -> next grant idx 1 (ptr wrapped to 0), and idx 7 is not regranted.
- Reset mid-grant: owner idx 3 active, rst_n=0 for one edge -> all outputs 0 the next cycle; after release with req=8'b0000_1001, idx 0 is granted because ptr was reset to 0.
